mul_ucode_seq: RTL

- Multi-cycle microcode sequencer for the MULR and MULI instructions.
- Accepts the decoder's mul_trigger/mul_type request and stalls the front end while it runs.
- Reads operands through a dedicated register-file port and runs a shift-add multiply over an internal accumulator.
- Writes the low DATA_W bits of the product back to the register file, then optionally updates N/Z flags.

---
 rtl/mul_ucode_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mul_ucode_seq.sv
// Multi-cycle shift-add multiply sequencer for MULR/MULI; stalls decode while running.
// Optional MUL_EARLY_TERM_EN: EXEC exits as soon as the remaining multiplier is zero.
module mul_ucode_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mul_trigger,
    input  logic              mul_type,
    input  logic              set_flags,
    input  logic [3:0]        dest_reg,
    input  logic [3:0]        src1_reg,
    input  logic [3:0]        src2_reg,
    input  logic [15:0]       imm,
    output logic              rf_ren,
    output logic [3:0]        rf_raddr1,
    output logic [3:0]        rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_wen,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_wen,
    output logic              flag_n,
    output logic              flag_z,
    output logic              stall,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] LOAD    = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] WB      = 3'd4;
    localparam logic [2:0] RELEASE = 3'd5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        dest_q, dest_d;
    logic [3:0]        src1_q, src1_d;
    logic [3:0]        src2_q, src2_d;
    logic              type_q, type_d;
    logic              flags_q, flags_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mplier_shift;
    logic              exec_last;

    assign mplier_shift = mplier_q >> 1;

`ifdef MUL_EARLY_TERM_EN
    assign exec_last = (cnt_q == LAST_ITER) || (mplier_shift == '0);
`else
    assign exec_last = (cnt_q == LAST_ITER);
`endif

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        type_d   = type_q;
        flags_d  = flags_q;
        imm_d    = imm_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (mul_trigger) begin
                    dest_d  = dest_reg;
                    src1_d  = src1_reg;
                    src2_d  = src2_reg;
                    type_d  = mul_type;
                    flags_d = set_flags;
                    imm_d   = DATA_W'($signed(imm));
                    state_d = READ;
                end
            end
            READ: state_d = LOAD;
            LOAD: begin
                mcand_d  = rf_rdata1;
                mplier_d = type_q ? rf_rdata2 : imm_q;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = EXEC;
            end
            EXEC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + 1'b1;
                if (exec_last) begin
                    state_d = WB;
                end
            end
            WB:      state_d = RELEASE;
            // Trigger is deliberately not sampled here: decode is moving past the held op.
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            dest_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            type_q   <= 1'b0;
            flags_q  <= 1'b0;
            imm_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            type_q   <= type_d;
            flags_q  <= flags_d;
            imm_q    <= imm_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        rf_ren    = 1'b0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        rf_wen    = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        flag_wen  = 1'b0;
        flag_n    = 1'b0;
        flag_z    = 1'b0;
        stall     = 1'b0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        case (state_q)
            // Gated with rst so every output reads 0 while reset is held.
            IDLE: stall = mul_trigger & rst;
            READ: begin
                stall     = 1'b1;
                rf_ren    = 1'b1;
                rf_raddr1 = src1_q;
                rf_raddr2 = type_q ? src2_q : 4'd0;
            end
            LOAD, EXEC: stall = 1'b1;
            WB: begin
                stall    = 1'b1;
                rf_wen   = 1'b1;
                rf_waddr = dest_q;
                rf_wdata = acc_q;
                if (flags_q) begin
                    flag_wen = 1'b1;
                    flag_n   = acc_q[DATA_W-1];
                    flag_z   = (acc_q == '0);
                end
            end
            RELEASE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
